// File: rtl/serial_transfer.sv
// ----------------------------------------------------------------------------
// serial_transfer
//   Captures one word of memory read data on a strobe from the RW flow
//   controller and sends it out either bit-serially (MSB first, one bit per
//   cycle) or as a whole word in a single cycle. A one-cycle TransferDone
//   pulse is returned when the transfer has finished.
//
// Parameters
//   DATA_WIDTH    width of the captured / transferred word
//
// Ports
//   Clk           system clock, rising edge
//   Reset         asynchronous, active-high reset
//   SampleData    capture DataIn (honoured only while idle)
//   TransferData  start the transfer of the captured word
//   Mode          1 = serial, 0 = parallel (latched when the transfer starts)
//   DataIn        read data from memory
//   SerialOut     serial data bit, MSB first
//   ParallelOut   parallel data word
//   OutValid      SerialOut / ParallelOut carry valid data
//   TransferDone  one-cycle end-of-transfer pulse
//   Loaded        a captured word is waiting or being transferred
//
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module serial_transfer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  SampleData,
    input  logic                  TransferData,
    input  logic                  Mode,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic                  SerialOut,
    output logic [DATA_WIDTH-1:0] ParallelOut,
    output logic                  OutValid,
    output logic                  TransferDone,
    output logic                  Loaded
);

    // Counter holds 0..DATA_WIDTH without wrapping.
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    // Bit-select width into the captured word.
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        SHIFT  = 3'd2,
        PAR    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   shreg_q;   // captured word, never shifted in place
    logic [CW-1:0]           cnt_q;     // number of serial bits already driven
    logic                    mode_q;    // Mode latched at transfer start
    logic                    ser_q;
    logic [DATA_WIDTH-1:0]   par_q;
    logic                    vld_q;
    logic                    done_q;
    logic                    loaded_q;

    // Next bit to drive: counting down from the MSB as bits go out.
    logic [IW-1:0]           bit_idx;
    assign bit_idx = IW'(DATA_WIDTH - 1) - IW'(cnt_q);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            ser_q    <= 1'b0;
            par_q    <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    done_q <= 1'b0;
                    // TransferData alone does nothing here; sampling wins
                    // even when both are high.
                    if (SampleData) begin
                        shreg_q  <= DataIn;
                        loaded_q <= 1'b1;
                        state_q  <= LOADED;
                    end
                end

                LOADED: begin
                    if (TransferData) begin
                        mode_q <= Mode;
                        vld_q  <= 1'b1;
                        // The MSB goes out on the same edge that starts
                        // the transfer, so the counter starts at 1.
                        if (Mode) begin
                            ser_q   <= shreg_q[DATA_WIDTH-1];
                            cnt_q   <= CW'(1);
                            state_q <= SHIFT;
                        end else begin
                            par_q   <= shreg_q;
                            state_q <= PAR;
                        end
                    end
                end

                SHIFT: begin
                    // TransferData is no longer looked at: once started,
                    // every bit is sent.
                    if (cnt_q < CW'(DATA_WIDTH)) begin
                        ser_q <= shreg_q[bit_idx];
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        if (mode_q) ser_q <= 1'b0;
                        else        par_q <= '0;
                        vld_q    <= 1'b0;
                        done_q   <= 1'b1;
                        loaded_q <= 1'b0;
                        state_q  <= DONE;
                    end
                end

                PAR: begin
                    if (mode_q) ser_q <= 1'b0;
                    else        par_q <= '0;
                    vld_q    <= 1'b0;
                    done_q   <= 1'b1;
                    loaded_q <= 1'b0;
                    state_q  <= DONE;
                end

                DONE: begin
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q  <= IDLE;
                    ser_q    <= 1'b0;
                    par_q    <= '0;
                    vld_q    <= 1'b0;
                    done_q   <= 1'b0;
                    loaded_q <= 1'b0;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign SerialOut    = ser_q;
    assign ParallelOut  = par_q;
    assign OutValid     = vld_q;
    assign TransferDone = done_q;
    assign Loaded       = loaded_q;

endmodule

// File: tb/tb_serial_transfer.sv
// ----------------------------------------------------------------------------
// tb_serial_transfer
//   Drives directed scenarios followed by randomized traffic into
//   serial_transfer. The reference model works at transaction level: when a
//   transfer starts it appends the whole expected output trace (data cycles,
//   done pulse, return-to-idle cycle) to a queue, and while that queue is
//   non-empty every input is ignored.
// ----------------------------------------------------------------------------
module tb_serial_transfer;

    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          SampleData = 1'b0;
    logic          TransferData = 1'b0;
    logic          Mode = 1'b0;
    logic [DW-1:0] DataIn = '0;
    logic          SerialOut;
    logic [DW-1:0] ParallelOut;
    logic          OutValid;
    logic          TransferDone;
    logic          Loaded;

    serial_transfer #(.DATA_WIDTH(DW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .SampleData   (SampleData),
        .TransferData (TransferData),
        .Mode         (Mode),
        .DataIn       (DataIn),
        .SerialOut    (SerialOut),
        .ParallelOut  (ParallelOut),
        .OutValid     (OutValid),
        .TransferDone (TransferDone),
        .Loaded       (Loaded)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          ov;
        logic          so;
        logic          td;
        logic          ld;
        logic [DW-1:0] po;
    } out_t;

    out_t          exp_q[$];
    out_t          exp_o;
    bit            have;
    logic [DW-1:0] word;

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp)
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        else
            n_pass++;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ov"}, 32'(OutValid),     32'(exp_o.ov));
        chk({tag, ".so"}, 32'(SerialOut),    32'(exp_o.so));
        chk({tag, ".po"}, 32'(ParallelOut),  32'(exp_o.po));
        chk({tag, ".td"}, 32'(TransferDone), 32'(exp_o.td));
        chk({tag, ".ld"}, 32'(Loaded),       32'(exp_o.ld));
    endtask

    task automatic model_clear();
        exp_q.delete();
        have  = 1'b0;
        word  = '0;
        exp_o = '0;
    endtask

    // One clock edge of the reference behaviour, using the inputs as driven.
    task automatic model_edge();
        out_t e;
        e = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else if (!have) begin
            if (SampleData) begin
                have = 1'b1;
                word = DataIn;
                e.ld = 1'b1;
            end
        end else if (TransferData) begin
            out_t t;
            have = 1'b0;
            if (Mode) begin
                for (int i = DW - 1; i >= 0; i--) begin
                    t = '0; t.ov = 1'b1; t.so = word[i]; t.ld = 1'b1;
                    exp_q.push_back(t);
                end
            end else begin
                t = '0; t.ov = 1'b1; t.ld = 1'b1; t.po = word;
                exp_q.push_back(t);
            end
            t = '0; t.td = 1'b1;
            exp_q.push_back(t);
            exp_q.push_back('0);
            e = exp_q.pop_front();
        end else begin
            e.ld = 1'b1;
        end
        exp_o = e;
    endtask

    task automatic cyc(input string tag);
        @(posedge Clk);
        if (Reset) model_clear();
        else       model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic drive(input logic sd, input logic td, input logic md, input logic [DW-1:0] d);
        SampleData   = sd;
        TransferData = td;
        Mode         = md;
        DataIn       = d;
    endtask

    // Asynchronous reset between edges: outputs must drop before any edge.
    task automatic async_reset(input string tag);
        #2;
        Reset = 1'b1;
        #1;
        model_clear();
        chk_all(tag);
        drive(0, 0, 0, '0);
        cyc(tag);
        Reset = 1'b0;
    endtask

    initial begin
        model_clear();
        // Reset held 20 ns, checked while asserted.
        #15;
        chk_all("rst_hold");
        #5;
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) cyc("idle");

        // Serial transfer of A5.
        drive(1, 0, 0, 8'hA5); cyc("a5_samp");
        drive(0, 1, 1, 8'h00); cyc("a5_start");
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 12; i++) cyc("a5_run");

        // Parallel transfer of 3C.
        drive(1, 0, 0, 8'h3C); cyc("3c_samp");
        drive(0, 1, 0, 8'h00); cyc("3c_start");
        drive(0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) cyc("3c_run");

        // TransferData with nothing captured.
        drive(0, 1, 1, 8'h77);
        for (int i = 0; i < 5; i++) cyc("nosamp");
        drive(0, 0, 0, 8'h00); cyc("nosamp_end");

        // Serial FF with a stray sample of 00 in the 4th bit cycle.
        drive(1, 0, 0, 8'hFF); cyc("ff_samp");
        drive(0, 1, 1, 8'h00); cyc("ff_b1");
        drive(0, 0, 0, 8'h00); cyc("ff_b2");
        cyc("ff_b3");
        drive(1, 1, 0, 8'h00); cyc("ff_b4");
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) cyc("ff_run");

        // Reset after 3 serial bits of A5, then 5A completes normally.
        drive(1, 0, 0, 8'hA5); cyc("ab_samp");
        drive(0, 1, 1, 8'h00); cyc("ab_b1");
        drive(0, 1, 1, 8'h00); cyc("ab_b2");
        cyc("ab_b3");
        async_reset("ab_rst");
        for (int i = 0; i < 3; i++) cyc("ab_post");
        drive(1, 0, 0, 8'h5A); cyc("5a_samp");
        drive(0, 1, 1, 8'h00); cyc("5a_start");
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 11; i++) cyc("5a_run");

        // Sample and TransferData together while idle.
        drive(1, 1, 0, 8'hC3); cyc("both_samp");
        cyc("both_start");
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) cyc("both_run");

        // Randomized traffic with occasional mid-flight resets.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom), DW'($urandom));
            cyc("rnd");
            if ($urandom_range(0, 150) == 0) async_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
